// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: controller <-> datapath/memory control and status bundle
interface multicycle_controller_if #(parameter int ALU_OP_W = 3);
  logic [10:0]         opcode;
  logic [4:0]          cond;
  logic                alu_z;
  logic                alu_n;
  logic                alu_c;
  logic                alu_v;
  logic                imem_ack;
  logic                dmem_ack;
  logic                imem_req;
  logic                ir_we;
  logic                pc_we;
  logic [1:0]          pc_src;
  logic [ALU_OP_W-1:0] alu_op;
  logic                alu_src_imm;
  logic                flag_we;
  logic                dmem_req;
  logic                dmem_we;
  logic                dmem_word;
  logic                reg_we;
  logic                wb_sel;
  logic                retire;
  logic [2:0]          state;
  modport master (
    input  opcode, cond, alu_z, alu_n, alu_c, alu_v, imem_ack, dmem_ack,
    output imem_req, ir_we, pc_we, pc_src, alu_op, alu_src_imm, flag_we,
           dmem_req, dmem_we, dmem_word, reg_we, wb_sel, retire, state
  );
  modport slave (
    output opcode, cond, alu_z, alu_n, alu_c, alu_v, imem_ack, dmem_ack,
    input  imem_req, ir_we, pc_we, pc_src, alu_op, alu_src_imm, flag_we,
           dmem_req, dmem_we, dmem_word, reg_we, wb_sel, retire, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: LEGv8 multicycle FETCH/DECODE/EXEC/MEM/WB sequencer with NZCV register
module multicycle_controller (
  input logic                     clk,
  input logic                     reset_n,
  multicycle_controller_if.master bus
);
  typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4} state_t;
  state_t st, nx;
  logic [3:0] nzcv;
  logic is_add, is_sub, is_and, is_orr, is_eor, is_lsl, is_andi, is_subs;
  logic is_ld, is_st, is_word, is_b, is_bc, is_br, is_alu, is_mem, taken;
  logic [2:0] dec_op;
  assign is_add  = bus.opcode == 11'h458;
  assign is_sub  = bus.opcode == 11'h658;
  assign is_and  = bus.opcode == 11'h450;
  assign is_orr  = bus.opcode == 11'h550;
  assign is_eor  = bus.opcode == 11'h650;
  assign is_lsl  = bus.opcode == 11'h69B;
  assign is_andi = bus.opcode[10:1] == 10'b1001000100;
  assign is_subs = bus.opcode == 11'h758;
  assign is_ld   = bus.opcode == 11'h7C2 || bus.opcode == 11'h5C4;
  assign is_st   = bus.opcode == 11'h7C0 || bus.opcode == 11'h5C0;
  assign is_word = bus.opcode == 11'h5C4 || bus.opcode == 11'h5C0;
  assign is_b    = bus.opcode[10:5] == 6'b000101;
  assign is_bc   = bus.opcode[10:3] == 8'b01010100;
  assign is_br   = bus.opcode == 11'h6B0;
  assign is_alu  = is_add | is_sub | is_and | is_orr | is_eor | is_lsl | is_andi | is_subs;
  assign is_mem  = is_ld | is_st;
  // GT: Z clear and N equals V, judged on the last retired SUBS
  assign taken   = bus.cond == 5'h0C && !nzcv[2] && nzcv[3] == nzcv[0];
  assign dec_op  = (is_sub | is_subs) ? 3'd1 :
                   (is_and | is_andi) ? 3'd2 :
                   is_orr             ? 3'd3 :
                   is_eor             ? 3'd4 :
                   is_lsl             ? 3'd5 : 3'd0;
  assign bus.state = st;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st   <= FETCH;
      nzcv <= 4'd0;
    end else begin
      st <= nx;
      if (bus.flag_we) nzcv <= {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v};
    end
  end
  always_comb begin
    nx              = FETCH;
    bus.imem_req    = 1'b0;
    bus.ir_we       = 1'b0;
    bus.pc_we       = 1'b0;
    bus.pc_src      = 2'b00;
    bus.alu_op      = 3'd0;
    bus.alu_src_imm = 1'b0;
    bus.flag_we     = 1'b0;
    bus.dmem_req    = 1'b0;
    bus.dmem_we     = 1'b0;
    bus.dmem_word   = 1'b0;
    bus.reg_we      = 1'b0;
    bus.wb_sel      = 1'b0;
    bus.retire      = 1'b0;
    case (st)
      FETCH: begin
        bus.imem_req = 1'b1;
        bus.ir_we    = bus.imem_ack;
        nx           = bus.imem_ack ? DECODE : FETCH;
      end
      DECODE: nx = EXEC;
      EXEC: begin
        bus.alu_op      = dec_op;
        bus.alu_src_imm = is_andi | is_mem;
        bus.flag_we     = is_subs;
        bus.pc_we       = !(is_alu | is_mem);
        bus.retire      = !(is_alu | is_mem);
        bus.pc_src      = (is_b || (is_bc && taken)) ? 2'b01 : is_br ? 2'b10 : 2'b00;
        nx              = is_alu ? WB : is_mem ? MEM : FETCH;
      end
      MEM: begin
        bus.dmem_req  = 1'b1;
        bus.dmem_we   = is_st;
        bus.dmem_word = is_word;
        bus.pc_we     = bus.dmem_ack & is_st;
        bus.retire    = bus.dmem_ack & is_st;
        nx            = !bus.dmem_ack ? MEM : is_st ? FETCH : WB;
      end
      WB: begin
        bus.reg_we = 1'b1;
        bus.wb_sel = is_ld;
        bus.pc_we  = 1'b1;
        bus.retire = 1'b1;
      end
      default: nx = FETCH;
    endcase
    // outputs are held low for as long as reset is asserted
    if (!reset_n) begin
      nx              = FETCH;
      bus.imem_req    = 1'b0;
      bus.ir_we       = 1'b0;
      bus.pc_we       = 1'b0;
      bus.pc_src      = 2'b00;
      bus.alu_op      = 3'd0;
      bus.alu_src_imm = 1'b0;
      bus.flag_we     = 1'b0;
      bus.dmem_req    = 1'b0;
      bus.dmem_we     = 1'b0;
      bus.dmem_word   = 1'b0;
      bus.reg_we      = 1'b0;
      bus.wb_sel      = 1'b0;
      bus.retire      = 1'b0;
    end
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: randomized per-instruction trace model checks of the multicycle controller
module tb_multicycle_controller;
  logic clk = 1'b0;
  logic reset_n;
  int vectors = 0;
  int miscompares = 0;
  logic [3:0] nzcv_m;
  multicycle_controller_if bus();
  multicycle_controller dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;

  localparam int K_ALU = 0, K_SUBS = 1, K_LD = 2, K_ST = 3, K_B = 4, K_BC = 5, K_BR = 6, K_NOP = 7;
  typedef struct {
    logic [18:0] v;
    bit          ack;
    bit          cap;
  } ent_t;
  logic [10:0] ops [20] = '{11'h458, 11'h658, 11'h450, 11'h550, 11'h650, 11'h69B, 11'h488, 11'h489,
                            11'h758, 11'h7C2, 11'h5C4, 11'h7C0, 11'h5C0, 11'h0A0, 11'h0BF, 11'h2A0,
                            11'h2A7, 11'h6B0, 11'h7FF, 11'h000};

  function automatic logic [18:0] mk(input logic [2:0] s, input logic ireq, input logic irwe,
                                     input logic pcwe, input logic [1:0] pcs, input logic [2:0] aop,
                                     input logic imm, input logic fwe, input logic dreq,
                                     input logic dwe, input logic dwd, input logic rwe,
                                     input logic wbs, input logic ret);
    return {s, ireq, irwe, pcwe, pcs, aop, imm, fwe, dreq, dwe, dwd, rwe, wbs, ret};
  endfunction

  function automatic int kind_of(input logic [10:0] op);
    if (op == 11'h758) return K_SUBS;
    if (op == 11'h458 || op == 11'h658 || op == 11'h450 || op == 11'h550 || op == 11'h650 ||
        op == 11'h69B || op == 11'h488 || op == 11'h489) return K_ALU;
    if (op == 11'h7C2 || op == 11'h5C4) return K_LD;
    if (op == 11'h7C0 || op == 11'h5C0) return K_ST;
    if (op >= 11'h0A0 && op <= 11'h0BF) return K_B;
    if (op >= 11'h2A0 && op <= 11'h2A7) return K_BC;
    if (op == 11'h6B0) return K_BR;
    return K_NOP;
  endfunction

  function automatic logic [2:0] aop_of(input logic [10:0] op);
    case (op)
      11'h658, 11'h758:          return 3'd1;
      11'h450, 11'h488, 11'h489: return 3'd2;
      11'h550:                   return 3'd3;
      11'h650:                   return 3'd4;
      11'h69B:                   return 3'd5;
      default:                   return 3'd0;
    endcase
  endfunction

  function automatic logic [18:0] sample();
    return {bus.state, bus.imem_req, bus.ir_we, bus.pc_we, bus.pc_src, bus.alu_op, bus.alu_src_imm,
            bus.flag_we, bus.dmem_req, bus.dmem_we, bus.dmem_word, bus.reg_we, bus.wb_sel, bus.retire};
  endfunction

  // Runs one instruction (or its first `cut` cycles) against the expected cycle trace.
  task automatic run_instr(input string nm, input logic [10:0] op, input logic [4:0] cd,
                           input int iw, input int dw, input logic [3:0] fl, input bit stray,
                           input int cut);
    ent_t q[$];
    int k;
    logic ls, wd, tk;
    logic [1:0] pcs;
    logic [18:0] obs;
    logic [2:0] s;
    k  = kind_of(op);
    ls = (k == K_ST);
    wd = (op == 11'h5C4 || op == 11'h5C0);
    tk = (cd == 5'h0C) && !nzcv_m[2] && (nzcv_m[3] == nzcv_m[0]);
    for (int i = 0; i < iw; i++) q.push_back('{mk(0,1,0,0,0,0,0,0,0,0,0,0,0,0), 1'b0, 1'b0});
    q.push_back('{mk(0,1,1,0,0,0,0,0,0,0,0,0,0,0), 1'b1, 1'b0});
    q.push_back('{mk(1,0,0,0,0,0,0,0,0,0,0,0,0,0), 1'b0, 1'b0});
    if (k == K_ALU || k == K_SUBS) begin
      q.push_back('{mk(2,0,0,0,0,aop_of(op),(op == 11'h488 || op == 11'h489),(k == K_SUBS),0,0,0,0,0,0),
                    1'b0, (k == K_SUBS)});
      q.push_back('{mk(4,0,0,1,0,0,0,0,0,0,0,1,0,1), 1'b0, 1'b0});
    end else if (k == K_LD || k == K_ST) begin
      q.push_back('{mk(2,0,0,0,0,0,1,0,0,0,0,0,0,0), 1'b0, 1'b0});
      for (int i = 0; i < dw; i++) q.push_back('{mk(3,0,0,0,0,0,0,0,1,ls,wd,0,0,0), 1'b0, 1'b0});
      q.push_back('{mk(3,0,0,ls,0,0,0,0,1,ls,wd,0,0,ls), 1'b1, 1'b0});
      if (!ls) q.push_back('{mk(4,0,0,1,0,0,0,0,0,0,0,1,1,1), 1'b0, 1'b0});
    end else begin
      pcs = (k == K_B || (k == K_BC && tk)) ? 2'b01 : (k == K_BR) ? 2'b10 : 2'b00;
      q.push_back('{mk(2,0,0,1,pcs,0,0,0,0,0,0,0,0,1), 1'b0, 1'b0});
    end
    for (int j = 0; j < q.size() && (cut < 0 || j < cut); j++) begin
      @(negedge clk);
      bus.opcode = op;
      bus.cond   = cd;
      s = q[j].v[18:16];
      bus.imem_ack = (s == 3'd0) ? q[j].ack : (stray | 1'($urandom_range(0, 1)));
      bus.dmem_ack = (s == 3'd3) ? q[j].ack : (stray | 1'($urandom_range(0, 1)));
      {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v} = q[j].cap ? fl : 4'($urandom);
      #1;
      obs = sample();
      vectors++;
      if (obs !== q[j].v) begin
        miscompares++;
        $display("FAIL %s op=%h cyc=%0d: got %h expected %h", nm, op, j, obs, q[j].v);
      end
      if (q[j].cap) nzcv_m = fl;
    end
  endtask

  task automatic check_now(input string nm, input logic [18:0] exp);
    logic [18:0] obs;
    #1;
    obs = sample();
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, obs, exp);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.imem_ack = 1'b1;
      bus.dmem_ack = 1'b1;
      check_now("reset_hold", '0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    bus.imem_ack = 1'b0;
    check_now("reset_release", mk(0,1,0,0,0,0,0,0,0,0,0,0,0,0));
    run_instr("subs_pre", 11'h758, 5'd0, 0, 0, 4'b0100, 1'b0, -1);
    run_instr("stur_cut", 11'h7C0, 5'd0, 0, 6, 4'd0, 1'b0, 5);
    @(negedge clk);
    reset_n = 1'b0;
    bus.dmem_ack = 1'b1;
    check_now("reset_mid_mem", '0);
    @(negedge clk);
    bus.imem_ack = 1'b1;
    check_now("reset_mid_hold", '0);
    nzcv_m = 4'd0;
    @(negedge clk);
    reset_n = 1'b1;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    check_now("reset_refetch", mk(0,1,0,0,0,0,0,0,0,0,0,0,0,0));
    run_instr("bcond_after_reset", 11'h2A0, 5'h0C, 0, 0, 4'($urandom), 1'b0, -1);
  endtask

  task automatic test_add();
    run_instr("add", 11'h458, 5'($urandom), 0, 0, 4'($urandom), 1'b0, -1);
  endtask

  task automatic test_ldursw();
    run_instr("ldursw", 11'h5C4, 5'($urandom), 0, 3, 4'($urandom), 1'b0, -1);
  endtask

  task automatic test_bcond();
    run_instr("subs_gt", 11'h758, 5'd0, 0, 0, 4'b1001, 1'b0, -1);
    run_instr("bcond_taken", 11'h2A0, 5'h0C, 0, 0, 4'($urandom), 1'b0, -1);
    run_instr("subs_eq", 11'h758, 5'd0, 0, 0, 4'b1101, 1'b0, -1);
    run_instr("bcond_not_taken", 11'h2A0, 5'h0C, 0, 0, 4'($urandom), 1'b0, -1);
    run_instr("bcond_other_cond", 11'h2A3, 5'h0B, 1, 0, 4'($urandom), 1'b0, -1);
  endtask

  task automatic test_nop();
    run_instr("nop_7ff", 11'h7FF, 5'($urandom), 0, 0, 4'($urandom), 1'b1, -1);
  endtask

  task automatic test_stray_ack();
    run_instr("stray_fetch", 11'h458, 5'd0, 3, 0, 4'($urandom), 1'b1, -1);
    run_instr("stray_store", 11'h5C0, 5'd0, 2, 2, 4'($urandom), 1'b1, -1);
  endtask

  task automatic test_back_to_back();
    foreach (ops[i]) run_instr("b2b", ops[i], 5'h0C, 0, 0, 4'($urandom), 1'b0, -1);
  endtask

  task automatic test_random();
    logic [10:0] op;
    for (int n = 0; n < 300; n++) begin
      op = ($urandom_range(0, 4) == 0) ? 11'($urandom) : ops[$urandom_range(0, 19)];
      run_instr("rand", op, ($urandom_range(0, 1) == 1) ? 5'h0C : 5'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3), 4'($urandom),
                1'($urandom_range(0, 1)), -1);
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    nzcv_m       = 4'd0;
    bus.opcode   = 11'd0;
    bus.cond     = 5'd0;
    bus.alu_z    = 1'b0;
    bus.alu_n    = 1'b0;
    bus.alu_c    = 1'b0;
    bus.alu_v    = 1'b0;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    test_reset();
    test_add();
    test_ldursw();
    test_bcond();
    test_nop();
    test_stray_ack();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
